// File: rtl/Packets.sv
// Shared decode types: op classes, opcode constants, decoded op bundle
// and the skid-buffer occupancy states.
package Packets;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_LOAD   = 8'h10;
  localparam logic [7:0] OP_STORE  = 8'h11;
  localparam logic [7:0] OP_BRANCH = 8'h20;
  localparam logic [7:0] OP_JUMP   = 8'h21;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MEM     = 3'd1,
    CLS_BR      = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } cls_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  opcode;
    cls_e        cls;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [63:0] imm;
    logic [7:0]  core;
  } decoded_op_t;

  function automatic cls_e op_class(
    input logic [7:0] op
  );
    cls_e c;
    c = CLS_ILLEGAL;
    unique case (1'b1)
      op == OP_NOP,
      op == OP_ADD,
      op == OP_SUB:    c = CLS_ALU;
      op == OP_LOAD,
      op == OP_STORE:  c = CLS_MEM;
      op == OP_BRANCH,
      op == OP_JUMP:   c = CLS_BR;
      op == OP_HALT:   c = CLS_HALT;
      default:         c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_insn_decoder.sv
// Pure combinational field split of a raw instruction word.
// Unknown opcodes are tagged ILLEGAL and passed through.
module insn_decoder
  import Packets::*;
(
  input  logic [31:0]  insn,
  input  logic [63:0]  pc,
  input  logic [7:0]   core_id,
  output decoded_op_t  op
);

  always_comb begin
    op        = '0;
    op.pc     = pc;
    op.opcode = insn[31:24];
    op.cls    = op_class(insn[31:24]);
    op.dst    = insn[23:20];
    op.src1   = insn[19:16];
    op.src2   = insn[15:12];
    op.imm    = {{52{insn[11]}}, insn[11:0]};
    op.core   = core_id;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: insn_decoder feeding a 2-entry skid buffer with halt.
// Define DECODE_STATS_EN to add decoded/stall counters.
module decode_stage
  import Packets::*;
#(
  parameter int unsigned core_id = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  in_insn,
  input  logic [63:0]  in_pc,
  output logic         in_ready,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output decoded_op_t  out_op,
  output logic         halted
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]  stat_decoded,
  output logic [31:0]  stat_stall_cycles
`endif
);

  localparam logic [7:0] CoreId = 8'(core_id);

  occ_e        state;
  occ_e        state_nxt;
  decoded_op_t dec;
  decoded_op_t buf0;
  decoded_op_t buf1;
  logic        in_xfer;
  logic        out_xfer;

  insn_decoder u_dec (
    .insn    (in_insn),
    .pc      (in_pc),
    .core_id (CoreId),
    .op      (dec)
  );

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_op   = buf0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (in_xfer) state_nxt = ST_ONE;
        ST_ONE: begin
          if (in_xfer && !out_xfer)      state_nxt = ST_TWO;
          else if (out_xfer && !in_xfer) state_nxt = ST_EMPTY;
        end
        ST_TWO: if (out_xfer) state_nxt = ST_ONE;
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // rst gates in_ready so nothing is offered while reset is held
  always_comb begin
    out_valid = (state != ST_EMPTY);
    in_ready  = (state != ST_TWO) && !halted && !flush && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0 <= '0;
      buf1 <= '0;
    end else if (!flush) begin
      unique case (state)
        ST_EMPTY: if (in_xfer) buf0 <= dec;
        ST_ONE: begin
          if (in_xfer && out_xfer) buf0 <= dec;
          else if (in_xfer)        buf1 <= dec;
        end
        ST_TWO: if (out_xfer) buf0 <= buf1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                halted <= 1'b0;
    else if (flush)                         halted <= 1'b0;
    else if (in_xfer && dec.cls == CLS_HALT) halted <= 1'b1;
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_decoded      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (in_xfer)
        stat_decoded <= stat_decoded + 32'd1;
      if (out_valid && !out_ready)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter core_id, default 0: core index, echoed on every decoded op.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  fetch stage presents an instruction.
REQ-005 in_insn  input  32  raw instruction word.
REQ-006 in_pc  input  64  address of in_insn (uint64_t).
REQ-007 in_ready  output  1  decode can accept this cycle.
REQ-008 flush  input  1  redirect from the store stage; discard all held ops.
REQ-009 out_valid  output  1  decoded op available.
REQ-010 out_ready  input  1  downstream accepts the op.
REQ-011 out_op  output  packed decoded_op_t: pc[64], opcode[8], cls[3], dst[4], src1[4], src2[4], imm[64], core[8].
REQ-012 halted  output  1  a HALT op has been accepted and not yet flushed.

Function
REQ-013 Field split: opcode=insn[31:24], dst=insn[23:20], src1=insn[19:16], src2=insn[15:12], imm=insn[11:0] sign-extended to 64 bits.
REQ-014 Opcode to cls mapping: 0x00 NOP->ALU, 0x01 ADD->ALU, 0x02 SUB->ALU, 0x10 LOAD->MEM, 0x11 STORE->MEM, 0x20 BRANCH->BR, 0x21 JUMP->BR, 0xFF HALT->HALT, any other value->ILLEGAL.
REQ-015 An input transfer occurs when in_valid and in_ready are both high at a posedge; an output transfer occurs when out_valid and out_ready are both high.
REQ-016 Ops are held in a 2-entry skid buffer whose occupancy FSM has states EMPTY, ONE and TWO.
REQ-017 FSM transitions: input only -> +1; output only -> -1; input and output together -> unchanged.
REQ-018 Latency: an op accepted at edge N drives out_valid at N+1 when the buffer was EMPTY.
REQ-019 Ordering is strict FIFO; no op is dropped or duplicated.
REQ-020 in_ready = (state != TWO) and not halted and not flush; it is combinational from registered state and flush.
REQ-021 out_valid = (state != EMPTY); out_op is the head entry and stays stable while out_valid is high and out_ready is low.
REQ-022 In TWO, a simultaneous output transfer does not allow an input transfer in the same cycle, because in_ready is already low.
REQ-023 Accepting a HALT op sets halted at the next edge; halted holds in_ready low and does not block draining of ops already buffered.
REQ-024 flush at an edge forces state to EMPTY and clears halted; it overrides any simultaneous input or output transfer.
REQ-025 An ILLEGAL op is passed downstream unchanged; decode takes no other action on it.

Reset
REQ-026 While rst is high: state=EMPTY, halted=0, out_valid=0, in_ready=0, out_op all-zero.
REQ-027 Asserting rst mid-transfer discards all buffered ops; after release, in_ready=1 at the first edge.

Configuration
REQ-028 Macro DECODE_STATS_EN, when defined, adds two outputs: stat_decoded[32] and stat_stall_cycles[32].
REQ-029 stat_decoded counts input transfers; stat_stall_cycles counts cycles with out_valid=1 and out_ready=0.
REQ-030 Both counters reset to 0, wrap at 2^32, and are unaffected by flush.
REQ-031 Without DECODE_STATS_EN, neither port nor the counter logic exists; all other behaviour is identical.

Structure
REQ-032 decoded_op_t, the cls enum (ALU=0, MEM=1, BR=2, HALT=3, ILLEGAL=4) and the opcode constants live in the shared Packets.sv package; they are not declared locally.
REQ-033 Field extraction is a pure combinational sub-module, insn_decoder (in: insn, pc, core_id; out: decoded_op_t).
REQ-034 decode_stage instantiates insn_decoder and holds the FSM, buffer and halt logic.

Verification
REQ-035 Streaming: insn 0x01321000 at pc 0x1000 with out_ready=1 -> next cycle out_valid=1, cls=ALU, dst=3, src1=2, src2=1, imm=0.
REQ-036 Sign extension: insn 0x10100FFF -> cls=MEM, imm=0xFFFFFFFFFFFFFFFF.
REQ-037 Backpressure: out_ready=0 while 3 ops are offered -> 2 are accepted and in_ready=0 after the 2nd; out_ready=1 then drains them in order.
REQ-038 Halt: ADD, HALT, ADD offered -> first 2 are emitted, halted=1, 3rd not accepted; flush pulse -> halted=0, in_ready=1.
REQ-039 Flush in TWO with in_valid=1 and out_ready=1 -> next cycle out_valid=0, nothing accepted or emitted that edge.
REQ-040 Reset mid-stream and illegal opcode: rst pulse with 2 ops buffered -> out_valid=0 immediately; insn 0x55000000 -> cls=ILLEGAL; with DECODE_STATS_EN, stat_decoded matches the transfer count.
